sweep_ctrl: RTL and testbench
=============================

SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, width of the phase increment (matches the sine generator incr input).
REQ-002 SHALL have parameter DW_WIDTH, default 8, width of the dwell count.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin a sweep; single-cycle pulse or level.
REQ-006 SHALL have port abort  input  1  terminate a running sweep without a done pulse.
REQ-007 SHALL have port loop  input  1  1 = restart from freq_start after the last step; 0 = single pass.
REQ-008 SHALL have port freq_start  input  D_WIDTH  first increment value.
REQ-009 SHALL have port freq_stop  input  D_WIDTH  highest increment value allowed.
REQ-010 SHALL have port freq_step  input  D_WIDTH  amount added to the increment per step.
REQ-011 SHALL have port dwell  input  DW_WIDTH  each step lasts dwell+1 enabled cycles.
REQ-012 SHALL have port en  output  1  enable to the sine generator address counter.
REQ-013 SHALL have port incr  output  D_WIDTH  increment to the sine generator.
REQ-014 SHALL have port busy  output  1  high while a sweep is running.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a non-looping sweep completes.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and DONE; all outputs SHALL be registered.
REQ-017 In IDLE, start=1 and abort=0 SHALL latch freq_start, freq_stop, freq_step, dwell and loop, load incr=freq_start, clear the dwell counter and enter RUN on the same edge.
REQ-018 In RUN, en=1 and busy=1; en SHALL first be high in the cycle after the edge that samples start.
REQ-019 The dwell counter SHALL increment on each RUN cycle; when it equals the latched dwell, the step SHALL end and the counter SHALL clear.
REQ-020 At step end, the next value SHALL be computed as incr+step in D_WIDTH+1 bits.
REQ-021 If that sum is <= stop and step != 0, incr SHALL take the sum on the next edge.
REQ-022 Otherwise, with loop=1, incr SHALL reload the latched start value and remain in RUN.
REQ-023 Otherwise, with loop=0, the FSM SHALL enter DONE; incr SHALL never wrap modulo 2^D_WIDTH.
REQ-024 In DONE, en=0, busy=0, done=1 for exactly one cycle, then IDLE; incr SHALL hold its last value.
REQ-025 abort=1 in RUN SHALL force IDLE on the next edge with en=0, busy=0, done=0; abort SHALL take priority over every other event.
REQ-026 start SHALL be ignored in RUN and DONE; input changes during RUN SHALL have no effect (latched copies are used).
REQ-027 If freq_start > freq_stop, one step SHALL run at freq_start, then completion (REQ-023) or reload (REQ-022).
REQ-028 With step=0 and loop=1, incr SHALL hold freq_start indefinitely until abort.
REQ-029 In IDLE, en=0, busy=0, done=0 and incr SHALL hold its last value.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, en=0, incr=0, busy=0, done=0, clear the dwell counter and clear all latched configuration, regardless of clk.
REQ-031 After rst deasserts, the block SHALL accept start on the first rising edge.

Structure
REQ-032 The FSM state enum (IDLE, RUN, DONE) SHALL live in shared package sigctrl_pkg.
REQ-033 No sub-module SHALL be used; the dwell counter and step adder SHALL be inline.
REQ-034 sweep_ctrl SHALL connect directly to the en and incr inputs of the sine generator.

Verification
REQ-035 start=5, stop=20, step=5, dwell=2, loop=0 -> incr sequence 5, 10, 15, 20, each held 3 en cycles; en high 12 cycles; done pulse in the following cycle.
REQ-036 start=250, stop=255, step=10, dwell=0, loop=0, D_WIDTH=8 -> one en cycle at incr=250, then done; incr never equals 4.
REQ-037 start=1, stop=3, step=1, dwell=0, loop=1 -> incr 1, 2, 3, 1, 2, 3 ...; abort after 7 cycles -> en=0 next cycle, done never asserted.
REQ-038 rst asserted mid-RUN, between clock edges -> en, incr, busy, done read 0 before the next edge.
REQ-039 Second start and freq_step changes while busy -> ignored; the original sequence completes unchanged.
REQ-040 step=0, loop=0, start=7 -> incr=7 for dwell+1 cycles, then done pulse.

Source files
------------

// File: rtl/sigctrl_pkg.sv
// Shared definitions for the signal-generator control blocks.
// Holds the sweep controller state encoding so neighbouring blocks decode it identically.
package sigctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sweep_state_t;

endpackage

// File: rtl/sweep_ctrl.sv
// Frequency sweep controller: steps the sine generator phase increment from a start
// value toward a stop value, holding each step for dwell+1 enabled cycles.
module sweep_ctrl #(
   parameter int D_WIDTH  = 8,
   parameter int DW_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                loop,
   input  logic [D_WIDTH-1:0]  freq_start,
   input  logic [D_WIDTH-1:0]  freq_stop,
   input  logic [D_WIDTH-1:0]  freq_step,
   input  logic [DW_WIDTH-1:0] dwell,
   output logic                en,
   output logic [D_WIDTH-1:0]  incr,
   output logic                busy,
   output logic                done
);

   import sigctrl_pkg::*;

   sweep_state_t        state;
   logic [DW_WIDTH-1:0] dw_cnt;
   logic [D_WIDTH-1:0]  start_q;
   logic [D_WIDTH-1:0]  stop_q;
   logic [D_WIDTH-1:0]  step_q;
   logic [DW_WIDTH-1:0] dwell_q;
   logic                loop_q;

   // The extra carry bit keeps an overflowing step from wrapping back below stop.
   logic [D_WIDTH:0]    sum;
   logic                step_ok;

   assign sum     = {1'b0, incr} + {1'b0, step_q};
   assign step_ok = (sum <= {1'b0, stop_q}) && (step_q != '0);

   // NOTE: all state here is sequential, so every assignment is non-blocking (<=);
   // blocking assignments would let later branches see half-updated registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         en      <= 1'b0;
         incr    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         dw_cnt  <= '0;
         start_q <= '0;
         stop_q  <= '0;
         step_q  <= '0;
         dwell_q <= '0;
         loop_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               en   <= 1'b0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start && !abort) begin
                  start_q <= freq_start;
                  stop_q  <= freq_stop;
                  step_q  <= freq_step;
                  dwell_q <= dwell;
                  loop_q  <= loop;
                  incr    <= freq_start;
                  dw_cnt  <= '0;
                  en      <= 1'b1;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end

            RUN: begin
               if (abort) begin
                  state  <= IDLE;
                  en     <= 1'b0;
                  busy   <= 1'b0;
                  done   <= 1'b0;
                  dw_cnt <= '0;
               end else if (dw_cnt == dwell_q) begin
                  dw_cnt <= '0;
                  if (step_ok) begin
                     incr <= sum[D_WIDTH-1:0];
                  end else if (loop_q) begin
                     incr <= start_q;
                  end else begin
                     state <= DONE;
                     en    <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  dw_cnt <= dw_cnt + 1'b1;
               end
            end

            DONE: begin
               state <= IDLE;
               en    <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end

            default: begin
               state <= IDLE;
               en    <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: directed sweeps plus randomized ones, each
// compared cycle by cycle against a list of expected increments built from the sweep rules.
module tb_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       loop;
   logic [7:0] freq_start;
   logic [7:0] freq_stop;
   logic [7:0] freq_step;
   logic [7:0] dwell;
   logic       en;
   logic [7:0] incr;
   logic       busy;
   logic       done;

   int vectors     = 0;
   int miscompares = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   sweep_ctrl #(.D_WIDTH(8), .DW_WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .loop       (loop),
      .freq_start (freq_start),
      .freq_stop  (freq_stop),
      .freq_step  (freq_step),
      .dwell      (dwell),
      .en         (en),
      .incr       (incr),
      .busy       (busy),
      .done       (done)
   );

   // Expected increment for every enabled cycle, from plain integer arithmetic.
   task automatic build_model(input int s, input int p, input int st, input int dw,
                              input bit lp, input int limit);
      int v;
      v = s;
      exp_q.delete();
      forever begin
         for (int k = 0; k <= dw; k++) exp_q.push_back(v);
         if (lp && exp_q.size() >= limit) break;
         if ((v + st) <= p && st != 0) v = v + st;
         else if (lp) v = s;
         else break;
      end
   endtask

   // Caller is between edges; abort_at > 0 aborts after that many enabled cycles.
   task automatic run_sweep(input string tag, input int s, input int p, input int st,
                            input int dw, input bit lp, input int abort_at, input bit disturb);
      int         n;
      bit         aborting;
      logic [7:0] last;
      logic [10:0] act;
      logic [10:0] req;
      build_model(s, p, st, dw, lp, abort_at);
      n        = (abort_at > 0 && abort_at <= exp_q.size()) ? abort_at : exp_q.size();
      aborting = (abort_at > 0 && n == abort_at);
      freq_start = 8'(s);
      freq_stop  = 8'(p);
      freq_step  = 8'(st);
      dwell      = 8'(dw);
      loop       = lp;
      abort      = 1'b0;
      start      = 1'b1;
      @(negedge clk);
      if (!disturb) start = 1'b0;
      for (int i = 0; i < n; i++) begin
         act = {en, busy, done, incr};
         req = {3'b110, 8'(exp_q[i])};
         vectors++;
         if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: en/busy/done/incr got %b/%b/%b/%0d want 1/1/0/%0d",
                     tag, i, en, busy, done, incr, exp_q[i]);
         end
         if (disturb) begin
            start      = 1'b1;
            freq_start = 8'($urandom);
            freq_stop  = 8'($urandom);
            freq_step  = 8'($urandom);
            dwell      = 8'($urandom_range(0, 3));
            loop       = 1'($urandom);
         end
         if (aborting && i == n - 1) abort = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      last  = 8'(exp_q[n-1]);
      if (aborting) begin
         for (int k = 0; k < 3; k++) begin
            act = {en, busy, done, incr};
            req = {3'b000, last};
            vectors++;
            if (act !== req) begin
               miscompares++;
               $display("FAIL %s after abort +%0d: en/busy/done/incr got %b/%b/%b/%0d want 0/0/0/%0d",
                        tag, k, en, busy, done, incr, last);
            end
            @(negedge clk);
         end
      end else begin
         act = {en, busy, done, incr};
         req = {3'b001, last};
         vectors++;
         if (act !== req) begin
            miscompares++;
            $display("FAIL %s done cycle: en/busy/done/incr got %b/%b/%b/%0d want 0/0/1/%0d",
                     tag, en, busy, done, incr, last);
         end
         @(negedge clk);
         act = {en, busy, done, incr};
         req = {3'b000, last};
         vectors++;
         if (act !== req) begin
            miscompares++;
            $display("FAIL %s post-done idle: en/busy/done/incr got %b/%b/%b/%0d want 0/0/0/%0d",
                     tag, en, busy, done, incr, last);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      loop = 1'b0;
      freq_start = '0;
      freq_stop = '0;
      freq_step = '0;
      dwell = '0;
      #1;
      vectors++;
      if ({en, busy, done, incr} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_state: en/busy/done/incr got %b/%b/%b/%0d want all 0",
                  en, busy, done, incr);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      run_sweep("ramp_5_20", 5, 20, 5, 2, 1'b0, 0, 1'b0);
   endtask

   task automatic test_no_wrap();
      run_sweep("no_wrap_250", 250, 255, 10, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_loop_abort();
      run_sweep("loop_abort", 1, 3, 1, 0, 1'b1, 7, 1'b0);
   endtask

   task automatic test_zero_step();
      run_sweep("zero_step_once", 7, 100, 0, 3, 1'b0, 0, 1'b0);
      run_sweep("zero_step_loop", 9, 200, 0, 1, 1'b1, 11, 1'b0);
      run_sweep("start_gt_stop", 40, 10, 3, 1, 1'b0, 0, 1'b0);
   endtask

   task automatic test_ignore_while_busy();
      run_sweep("busy_ignore", 5, 20, 5, 2, 1'b0, 0, 1'b1);
   endtask

   task automatic test_reset_mid_run();
      freq_start = 8'd12;
      freq_stop  = 8'd90;
      freq_step  = 8'd6;
      dwell      = 8'd1;
      loop       = 1'b1;
      start      = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({en, busy, done, incr} !== 11'd0) begin
         miscompares++;
         $display("FAIL reset_mid_run: en/busy/done/incr got %b/%b/%b/%0d want all 0",
                  en, busy, done, incr);
      end
      rst = 1'b0;
      // Start is presented before the very first edge after reset release.
      run_sweep("after_reset", 3, 9, 3, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_random();
      int s, p, st, dw, ab;
      bit lp;
      for (int r = 0; r < 20; r++) begin
         s  = $urandom_range(0, 255);
         p  = $urandom_range(0, 255);
         st = $urandom_range(0, 40);
         dw = $urandom_range(0, 3);
         lp = 1'($urandom_range(0, 1));
         ab = lp ? $urandom_range(1, 40) : 0;
         run_sweep("random", s, p, st, dw, lp, ab, 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_no_wrap();
      test_loop_abort();
      test_zero_step();
      test_ignore_while_busy();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
